// File: rtl/cb_cfg_pkg.sv
// Shared constants, FSM state encoding and address helpers for the X-direction
// connection-block configuration sequencer.
package cb_cfg_pkg;

   localparam int MEM_W = 4;
   localparam int BIT_W = 3;
   localparam int CNT_W = 6;

   localparam logic [MEM_W-1:0] NUM_MEMS    = 4'd11;
   localparam logic [MEM_W-1:0] NUM_WIDE    = 4'd9;
   localparam logic [BIT_W-1:0] WIDE_BITS   = 3'd6;
   localparam logic [BIT_W-1:0] NARROW_BITS = 3'd2;
   localparam logic [MEM_W-1:0] LAST_MEM    = NUM_MEMS - 4'd1;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_BIT,
      SETUP,
      STROBE,
      HOLD,
      DONE
   } state_t;

   function automatic logic [BIT_W-1:0] bits_per_mem(input logic [MEM_W-1:0] idx);
      return (idx < NUM_WIDE) ? WIDE_BITS : NARROW_BITS;
   endfunction

   // address[0] is the MSB of the bit field; narrow memories decode only address[0].
   function automatic logic [0:6] encode_addr(input logic [MEM_W-1:0] mem_idx,
                                              input logic [BIT_W-1:0] bit_idx);
      logic [0:6] a;
      a[3:6] = mem_idx;
      if (mem_idx < NUM_WIDE) begin
         a[0:2] = bit_idx;
      end else begin
         a[0]   = bit_idx[0];
         a[1:2] = 2'b00;
      end
      return a;
   endfunction

endpackage

// File: rtl/cbx_cfg_frame_ctrl_if.sv
// Bit stream, control/status and connection-block write port of the sequencer.
// master = programming-chain side, slave = the sequencer itself.
interface cbx_cfg_frame_ctrl_if;
   import cb_cfg_pkg::*;

   logic             start;
   logic [MEM_W-1:0] start_mem;
   logic [MEM_W-1:0] end_mem;
   logic             abort;
   logic             bit_valid;
   logic             bit_in;
   logic             bit_ready;
   logic             busy;
   logic             done;
   logic             err;
   logic [CNT_W-1:0] bits_written;
   logic [0:0]       enable;
   logic [0:6]       address;
   logic [0:0]       data_in;

   modport master (
      output start, start_mem, end_mem, abort, bit_valid, bit_in,
      input  bit_ready, busy, done, err, bits_written, enable, address, data_in
   );

   modport slave (
      input  start, start_mem, end_mem, abort, bit_valid, bit_in,
      output bit_ready, busy, done, err, bits_written, enable, address, data_in
   );

endinterface

// File: rtl/cb_cfg_addr_gen.sv
// Memory/bit index counters with last-bit/last-memory flags and address encode.
// Loads on an accepted start, steps once per written bit; purely combinational outputs.
module cb_cfg_addr_gen
   import cb_cfg_pkg::*;
(
   input  logic             prog_clk,
   input  logic             prog_rst_n,
   input  logic             load,
   input  logic             advance,
   input  logic [MEM_W-1:0] start_mem,
   input  logic [MEM_W-1:0] end_mem,
   output logic             last_bit,
   output logic             last_mem,
   output logic [0:6]       addr
);

   logic [MEM_W-1:0] mem_idx;
   logic [MEM_W-1:0] end_idx;
   logic [BIT_W-1:0] bit_idx;

   always_ff @(posedge prog_clk or negedge prog_rst_n) begin
      if (!prog_rst_n) begin
         mem_idx <= '0;
         end_idx <= '0;
         bit_idx <= '0;
      end else if (load) begin
         mem_idx <= start_mem;
         end_idx <= end_mem;
         bit_idx <= '0;
      end else if (advance) begin
         if (!last_bit) begin
            bit_idx <= bit_idx + 3'd1;
         end else if (!last_mem) begin
            mem_idx <= mem_idx + 4'd1;
            bit_idx <= '0;
         end
      end
   end

   assign last_bit = (bit_idx == (bits_per_mem(mem_idx) - 3'd1));
   assign last_mem = (mem_idx >= end_idx);
   assign addr     = encode_addr(mem_idx, bit_idx);

   a_bit_in_range: assert property (@(posedge prog_clk) disable iff (!prog_rst_n)
      bit_idx <= (bits_per_mem(mem_idx) - 3'd1));

   a_mem_in_range: assert property (@(posedge prog_clk) disable iff (!prog_rst_n)
      mem_idx <= end_idx);

endmodule

// File: rtl/cbx_cfg_frame_ctrl.sv
// Configuration write sequencer: one streamed bit per setup/strobe/hold write into the connection block.
// 4 cycles per bit with bit_valid held; stalls in WAIT_BIT while bit_valid is low; all outputs registered.
module cbx_cfg_frame_ctrl
   import cb_cfg_pkg::*;
(
   input  logic                 prog_clk,
   input  logic                 prog_rst_n,
   cbx_cfg_frame_ctrl_if.slave  cfg
);

   state_t     state;
   state_t     state_nxt;
   logic       load;
   logic       advance;
   logic       range_bad;
   logic       last_bit;
   logic       last_mem;
   logic [0:6] addr;

   cb_cfg_addr_gen u_addr_gen (
      .prog_clk   (prog_clk),
      .prog_rst_n (prog_rst_n),
      .load       (load),
      .advance    (advance),
      .start_mem  (cfg.start_mem),
      .end_mem    (cfg.end_mem),
      .last_bit   (last_bit),
      .last_mem   (last_mem),
      .addr       (addr)
   );

   assign range_bad = (cfg.start_mem > cfg.end_mem) || (cfg.end_mem > LAST_MEM);

   always_ff @(posedge prog_clk or negedge prog_rst_n) begin
      if (!prog_rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // abort always wins: it suppresses a pending strobe and leaves a presented bit unconsumed.
   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      advance   = 1'b0;
      case (state)
         IDLE: begin
            if (cfg.start && !cfg.abort && !range_bad) begin
               state_nxt = WAIT_BIT;
               load      = 1'b1;
            end
         end
         WAIT_BIT: begin
            if (cfg.abort) begin
               state_nxt = IDLE;
            end else if (cfg.bit_valid) begin
               state_nxt = SETUP;
            end
         end
         SETUP: begin
            state_nxt = cfg.abort ? IDLE : STROBE;
         end
         STROBE: begin
            state_nxt = cfg.abort ? IDLE : HOLD;
         end
         HOLD: begin
            if (cfg.abort) begin
               state_nxt = IDLE;
            end else begin
               advance   = 1'b1;
               state_nxt = (last_bit && last_mem) ? DONE : WAIT_BIT;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Outputs are decoded from the next state so they line up with the state they describe.
   always_ff @(posedge prog_clk or negedge prog_rst_n) begin
      if (!prog_rst_n) begin
         cfg.bit_ready    <= 1'b0;
         cfg.busy         <= 1'b0;
         cfg.done         <= 1'b0;
         cfg.err          <= 1'b0;
         cfg.bits_written <= '0;
         cfg.enable       <= '0;
         cfg.address      <= '0;
         cfg.data_in      <= '0;
      end else begin
         cfg.bit_ready <= (state_nxt == WAIT_BIT);
         cfg.busy      <= (state_nxt != IDLE);
         cfg.done      <= (state_nxt == DONE);
         cfg.enable    <= (state_nxt == STROBE);

         if (state == IDLE && cfg.start && !cfg.abort) begin
            cfg.err <= range_bad;
         end

         if (load) begin
            cfg.bits_written <= '0;
         end else if (state_nxt == STROBE) begin
            cfg.bits_written <= cfg.bits_written + 6'd1;
         end

         if (state == WAIT_BIT && state_nxt == SETUP) begin
            cfg.data_in <= cfg.bit_in;
            cfg.address <= addr;
         end
      end
   end

endmodule

// File: tb/tb_cbx_cfg_frame_ctrl.sv
// Self-checking bench for cbx_cfg_frame_ctrl: scoreboard of expected (address, data) writes
// pushed as bits are streamed in and popped on every observed enable strobe.
module tb_cbx_cfg_frame_ctrl;

   logic prog_clk   = 1'b0;
   logic prog_rst_n = 1'b1;

   always #5 prog_clk = ~prog_clk;

   cbx_cfg_frame_ctrl_if cfg();

   cbx_cfg_frame_ctrl dut (
      .prog_clk   (prog_clk),
      .prog_rst_n (prog_rst_n),
      .cfg        (cfg)
   );

   int   checks     = 0;
   int   failures   = 0;
   int   cyc        = 0;
   int   strobe_cnt = 0;
   int   done_cnt   = 0;
   int   last_cyc   = 0;
   bit   prev_en    = 1'b0;
   bit   have_last  = 1'b0;
   bit   spacing_on = 1'b0;
   logic bit_val    = 1'b1;
   logic [7:0] exp_q[$];

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference address: wide memories {bit[2:0], mem}, narrow memories {bit[0], 00, mem}.
   function automatic logic [6:0] model_addr(input int m, input int b);
      logic [3:0] mm;
      logic [2:0] bb;
      mm = 4'(m);
      bb = 3'(b);
      if (m < 9) return {bb, mm};
      return {bb[0], 2'b00, mm};
   endfunction

   function automatic int nbits(input int m);
      return (m < 9) ? 6 : 2;
   endfunction

   always @(posedge prog_clk) cyc <= cyc + 1;

   always @(negedge prog_clk) begin
      logic [7:0] e;
      if (cfg.enable[0] === 1'b1) begin
         strobe_cnt++;
         check_val("en_width", prev_en, 0);
         if (spacing_on && have_last) check_val("en_space", cyc - last_cyc, 4);
         last_cyc  = cyc;
         have_last = 1'b1;
         if (exp_q.size() == 0) begin
            check_val("unexp_strobe", exp_q.size(), 1);
         end else begin
            e = exp_q.pop_front();
            check_val("addr", cfg.address, e[7:1]);
            check_val("data", cfg.data_in, e[0]);
         end
      end
      if (cfg.done === 1'b1) done_cnt++;
      prev_en = (cfg.enable[0] === 1'b1);
   end

   task automatic pulse_start(input int s, input int e);
      cfg.start_mem = 4'(s);
      cfg.end_mem   = 4'(e);
      cfg.start     = 1'b1;
      @(negedge prog_clk);
      cfg.start     = 1'b0;
   endtask

   // Presents one bit and returns on the negedge just after the handshake edge.
   task automatic send_bit(input logic b);
      int t = 0;
      cfg.bit_valid = 1'b1;
      cfg.bit_in    = b;
      while (cfg.bit_ready !== 1'b1 && t < 40) begin
         @(negedge prog_clk);
         t++;
      end
      if (t >= 40) check_val("ready_wait", cfg.bit_ready, 1);
      @(negedge prog_clk);
   endtask

   task automatic load(input int s, input int e, input int stall_mem, input int stall_bit,
                       input int exp_done_cyc);
      int start_cyc;
      int strobes0;
      int total;
      int t;
      bit seen;
      strobes0  = strobe_cnt;
      total     = 0;
      start_cyc = cyc;
      pulse_start(s, e);
      check_val("err_clr", cfg.err, 0);
      check_val("busy_run", cfg.busy, 1);
      for (int m = s; m <= e; m++) begin
         for (int b = 0; b < nbits(m); b++) begin
            if (m == stall_mem && b == stall_bit) begin
               cfg.bit_valid = 1'b0;
               t = 0;
               while (cfg.bit_ready !== 1'b1 && t < 8) begin
                  @(negedge prog_clk);
                  t++;
               end
               for (int i = 0; i < 20; i++) begin
                  check_val("stall_rdy", cfg.bit_ready, 1);
                  check_val("stall_en", cfg.enable, 0);
                  @(negedge prog_clk);
               end
            end
            exp_q.push_back({model_addr(m, b), bit_val});
            send_bit(bit_val);
            bit_val = ~bit_val;
            total++;
         end
      end
      cfg.bit_valid = 1'b0;
      seen = 1'b0;
      for (t = 0; t < 20 && !seen; t++) begin
         if (cfg.done === 1'b1) seen = 1'b1;
         else @(negedge prog_clk);
      end
      check_val("done_seen", seen, 1);
      // The cycle in which start is high counts as cycle 1.
      if (exp_done_cyc != 0) check_val("done_cyc", cyc - start_cyc + 1, exp_done_cyc);
      check_val("bits_written", cfg.bits_written, total);
      check_val("strobes", strobe_cnt - strobes0, total);
      check_val("sb_empty", exp_q.size(), 0);
      @(negedge prog_clk);
      check_val("done_width", cfg.done, 0);
      check_val("busy_end", cfg.busy, 0);
   endtask

   task automatic range_err(input int s, input int e);
      int s0;
      int d0;
      s0 = strobe_cnt;
      d0 = done_cnt;
      pulse_start(s, e);
      check_val("err_set", cfg.err, 1);
      check_val("err_busy", cfg.busy, 0);
      repeat (6) @(negedge prog_clk);
      check_val("err_busy_late", cfg.busy, 0);
      check_val("err_strobes", strobe_cnt - s0, 0);
      check_val("err_done", done_cnt - d0, 0);
   endtask

   task automatic abort_test();
      int s0;
      int d0;
      s0 = strobe_cnt;
      d0 = done_cnt;
      pulse_start(4, 6);
      for (int b = 0; b < 3; b++) begin
         exp_q.push_back({model_addr(4, b), bit_val});
         send_bit(bit_val);
         bit_val = ~bit_val;
      end
      send_bit(bit_val);
      bit_val = ~bit_val;
      cfg.abort     = 1'b1;
      cfg.bit_valid = 1'b0;
      @(negedge prog_clk);
      cfg.abort = 1'b0;
      check_val("abort_rdy", cfg.bit_ready, 0);
      check_val("abort_busy", cfg.busy, 0);
      check_val("abort_en", cfg.enable, 0);
      repeat (6) @(negedge prog_clk);
      check_val("abort_strobes", strobe_cnt - s0, 3);
      check_val("abort_done", done_cnt - d0, 0);
      check_val("abort_sb", exp_q.size(), 0);
   endtask

   task automatic reset_test();
      pulse_start(0, 0);
      send_bit(1'b1);
      cfg.bit_valid = 1'b0;
      @(posedge prog_clk);
      #2;
      check_val("rst_pre_en", cfg.enable, 1);
      prog_rst_n = 1'b0;
      #1;
      check_val("rst_en", cfg.enable, 0);
      check_val("rst_busy", cfg.busy, 0);
      check_val("rst_rdy", cfg.bit_ready, 0);
      check_val("rst_addr", cfg.address, 0);
      check_val("rst_bw", cfg.bits_written, 0);
      check_val("rst_data", cfg.data_in, 0);
      check_val("rst_done", cfg.done, 0);
      check_val("rst_err", cfg.err, 0);
      @(negedge prog_clk);
      prog_rst_n = 1'b1;
      repeat (5) begin
         @(negedge prog_clk);
         check_val("post_rst_busy", cfg.busy, 0);
         check_val("post_rst_en", cfg.enable, 0);
      end
   endtask

   initial begin
      cfg.start     = 1'b0;
      cfg.start_mem = '0;
      cfg.end_mem   = '0;
      cfg.abort     = 1'b0;
      cfg.bit_valid = 1'b0;
      cfg.bit_in    = 1'b0;
      #1 prog_rst_n = 1'b0;
      #1;
      check_val("init_en", cfg.enable, 0);
      check_val("init_busy", cfg.busy, 0);
      check_val("init_done", cfg.done, 0);
      check_val("init_err", cfg.err, 0);
      check_val("init_rdy", cfg.bit_ready, 0);
      check_val("init_addr", cfg.address, 0);
      check_val("init_bw", cfg.bits_written, 0);
      check_val("init_data", cfg.data_in, 0);
      repeat (3) @(negedge prog_clk);
      prog_rst_n = 1'b1;
      @(negedge prog_clk);

      spacing_on = 1'b1;
      have_last  = 1'b0;
      load(0, 10, -1, -1, 234);
      spacing_on = 1'b0;

      range_err(5, 3);
      range_err(5, 12);
      load(9, 10, -1, -1, 0);

      // start together with abort in IDLE is dropped, so a bad range must not raise err
      cfg.abort = 1'b1;
      pulse_start(5, 3);
      cfg.abort = 1'b0;
      check_val("abort_start_err", cfg.err, 0);
      check_val("abort_start_busy", cfg.busy, 0);

      load(0, 3, 2, 3, 0);
      abort_test();
      load(4, 4, -1, -1, 0);
      reset_test();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      failures++;
      $display("FAIL watchdog got=timeout exp=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog expired");
   end

endmodule
